// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_arb_pkg
//  Description : Shared types and constants for the AXI interconnect-slice
//                arbiters (write path and read path).
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

    // Write-path sequencing states: arbitration, address, data, response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_e;

    // Master identifier; doubles as the payload-mux select value
    typedef logic grant_t;

    localparam grant_t c_MST0 = 1'b0;
    localparam grant_t c_MST1 = 1'b1;

    // The master that is not g; used for the round-robin tie-break
    function automatic grant_t other_master(input grant_t g);
        return (g == c_MST0) ? c_MST1 : c_MST0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Combinational two-requester round-robin pick. A lone
//                requester always wins; on contention the requester that
//                was not granted last time wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_t     last_grant_i,
    output grant_t     grant_o,
    output logic       grant_valid_o
);

    // Pick a winner from the current request vector and the previous grant
    always_comb begin
        grant_valid_o = |req_i;
        grant_o       = c_MST0;
        case (req_i)
            2'b01:   grant_o = c_MST0;
            2'b10:   grant_o = c_MST1;
            2'b11:   grant_o = other_master(last_grant_i);
            default: grant_o = c_MST0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_wr_arbiter_2x1.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wr_arbiter_2x1
//  Description : Write-path arbiter for a 2-master / 1-slave slice. Drives
//                the select/enable of the AW and W payload muxes and routes
//                valid/ready so one master owns the write path from its AW
//                handshake through its B handshake. Round-robin grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_arbiter_2x1
    import axi_arb_pkg::*;
#(
    parameter int MAX_BEATS = 256,
    // Must satisfy 2**CNT_W > MAX_BEATS so the limit fits in the counter
    parameter int CNT_W     = 9
)(
    input  logic ACLK,
    input  logic ARESET,

    input  logic s0_awvalid,
    input  logic s1_awvalid,
    output logic s0_awready,
    output logic s1_awready,

    input  logic s0_wvalid,
    input  logic s1_wvalid,
    output logic s0_wready,
    output logic s1_wready,

    output logic s0_bvalid,
    output logic s1_bvalid,
    input  logic s0_bready,
    input  logic s1_bready,

    output logic m_awvalid,
    input  logic m_awready,
    output logic m_wvalid,
    input  logic m_wready,
    input  logic m_wlast,
    input  logic m_bvalid,
    output logic m_bready,

    output logic mux_sel,
    output logic mux_en,
    output logic busy,
    output logic err_overrun
);

    localparam logic [CNT_W-1:0] c_MAX_BEATS = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    wr_state_e        state_q,      state_d;
    grant_t           mux_sel_q,    mux_sel_d;
    grant_t           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic             err_q,        err_d;

    grant_t           w_grant;
    logic             w_grant_valid;
    logic             w_sel_awvalid;
    logic             w_sel_wvalid;
    logic             w_sel_bready;
    logic [CNT_W-1:0] w_cnt_inc;

    rr_arbiter_2 u_rr (
        .req_i         ({s1_awvalid, s0_awvalid}),
        .last_grant_i  (last_grant_q),
        .grant_o       (w_grant),
        .grant_valid_o (w_grant_valid)
    );

    // Granted master's request-side signals, selected by the registered grant
    always_comb begin
        w_sel_awvalid = (mux_sel_q == c_MST1) ? s1_awvalid : s0_awvalid;
        w_sel_wvalid  = (mux_sel_q == c_MST1) ? s1_wvalid  : s0_wvalid;
        w_sel_bready  = (mux_sel_q == c_MST1) ? s1_bready  : s0_bready;
        // Beat counter saturates rather than wrapping on a runaway burst
        w_cnt_inc     = (beat_cnt_q == {CNT_W{1'b1}}) ? beat_cnt_q
                                                      : beat_cnt_q + c_CNT_ONE;
    end

    // State and grant registers; reset leaves master0 as first winner
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            mux_sel_q    <= c_MST0;
            last_grant_q <= c_MST1;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state: grant in IDLE, then follow AW, W and B handshakes
    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (w_grant_valid) begin
                    mux_sel_d = w_grant;
                    state_d   = AW;
                end
            end
            AW: begin
                // A withdrawn awvalid simply leaves us waiting here
                if (w_sel_awvalid && m_awready) begin
                    beat_cnt_d = '0;
                    state_d    = W;
                end
            end
            W: begin
                if (w_sel_wvalid && m_wready) begin
                    beat_cnt_d = w_cnt_inc;
                    if (m_wlast) begin
                        state_d = B;
                    end else if (w_cnt_inc >= c_MAX_BEATS) begin
                        // Burst too long: flag it, keep draining until WLAST
                        err_d = 1'b1;
                    end
                end
            end
            B: begin
                if (m_bvalid && w_sel_bready) begin
                    last_grant_d = mux_sel_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake routing: only the granted master is ever connected
    always_comb begin
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        s1_bvalid  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state_q)
            AW: begin
                m_awvalid = w_sel_awvalid;
                if (mux_sel_q == c_MST1) s1_awready = m_awready;
                else                     s0_awready = m_awready;
            end
            W: begin
                m_wvalid = w_sel_wvalid;
                if (mux_sel_q == c_MST1) s1_wready = m_wready;
                else                     s0_wready = m_wready;
            end
            B: begin
                m_bready = w_sel_bready;
                if (mux_sel_q == c_MST1) s1_bvalid = m_bvalid;
                else                     s0_bvalid = m_bvalid;
            end
            default: begin
                m_awvalid = 1'b0;
            end
        endcase
    end

    assign mux_sel     = mux_sel_q;
    assign mux_en      = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: doc/axi_wr_arbiter_2x1.md
Name: axi_wr_arbiter_2x1

Overview:
- Write-path arbiter for a 2-master / 1-slave interconnect slice.
- Owns the `sel`/`enable` controls of the Mux_2x1_en instances that carry AW and W payloads. Sequences valid/ready for AW, W and B so that exactly one master owns the write path from AW handshake through B handshake.
- Masters are granted round-robin.

Parameters:
- MAX_BEATS, 256, maximum legal W beats per burst; exceeding it raises `err_overrun`.
- CNT_W, 9, beat counter width; must satisfy 2**CNT_W > MAX_BEATS.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- s0_awvalid, s1_awvalid  in  1  master AW valid.
- s0_awready, s1_awready  out  1  master AW ready.
- s0_wvalid, s1_wvalid  in  1  master W valid.
- s0_wready, s1_wready  out  1  master W ready.
- s0_bvalid, s1_bvalid  out  1  routed B valid.
- s0_bready, s1_bready  in  1  master B ready.
- m_awvalid  out  1  slave AW valid.
- m_awready  in  1  slave AW ready.
- m_wvalid  out  1  slave W valid.
- m_wready  in  1  slave W ready.
- m_wlast  in  1  WLAST taken from the W payload mux output.
- m_bvalid  in  1  slave B valid.
- m_bready  out  1  slave B ready.
- mux_sel  out  1  mux select to all payload muxes: 0 = master0, 1 = master1.
- mux_en  out  1  mux enable; 0 forces mux outputs to zero.
- busy  out  1  high whenever state != IDLE.
- err_overrun  out  1  sticky burst-overrun flag.

Behaviour:
- States: IDLE, AW, W, B.
  - `state`, `mux_sel`, `last_grant`, `beat_cnt` and `err_overrun` are registers.
  - All handshake outputs are combinational from state plus the granted master's signals.
- Reset (ARESET=1 at an edge) forces the following from the next cycle, regardless of the current state, including mid-burst:
  - state=IDLE, mux_sel=0, mux_en=0, last_grant=1 (so master0 wins first), beat_cnt=0, err_overrun=0.
  - All valid/ready outputs are 0 while in IDLE.
- IDLE:
  - No handshake outputs asserted.
  - If any awvalid is high, pick a winner:
    - Only one requester: it wins.
    - Both requesting: the master != last_grant wins.
  - Register `mux_sel`=winner and go to AW. Grant is visible the cycle after the request is sampled (1-cycle arbitration latency).
- AW:
  - mux_en=1.
  - m_awvalid = s{sel}_awvalid.
  - s{sel}_awready = m_awready.
  - The other master's awready=0.
  - On m_awvalid & m_awready: go to W, beat_cnt=0.
  - If the granted awvalid deasserts before the handshake (AXI violation), remain in AW.
- W:
  - mux_en=1.
  - m_wvalid = s{sel}_wvalid.
  - s{sel}_wready = m_wready.
  - Each W handshake increments beat_cnt (saturating at all-ones).
  - Handshake with m_wlast=1: go to B.
  - A handshake that takes beat_cnt to MAX_BEATS without m_wlast: set err_overrun and stay in W until WLAST arrives.
- B:
  - mux_en=1.
  - s{sel}_bvalid = m_bvalid.
  - m_bready = s{sel}_bready.
  - On handshake: last_grant=sel, go to IDLE. mux_en drops that next cycle.
  - A new request present in that same cycle is arbitrated in IDLE on the following cycle. Minimum gap between bursts is 1 IDLE cycle.
- Isolation: the non-granted master always sees awready=wready=bvalid=0, in every state.
- mux_sel holds its value through IDLE; it is only updated on a grant.
- W beats offered before AW completes are not accepted (wready=0 outside W).

Decomposition:
- Shared package `axi_arb_pkg`:
  - `wr_state_e` enum {IDLE, AW, W, B}.
  - `grant_t` (1-bit master id).
  - Localparams for master ids.
- Sub-module `rr_arbiter_2`: combinational 2-input round-robin pick (req[1:0], last_grant -> grant, grant_valid), reusable by the read-path arbiter.

Test Plan:
- Single request: after reset, s0_awvalid=1 at cycle 0 -> mux_sel=0, mux_en=1, m_awvalid=1 at cycle 1. 4-beat burst with wlast on beat 4 -> state B. B handshake -> IDLE, mux_en=0 next cycle.
- Contention and fairness: both awvalid held high for 3 consecutive 1-beat bursts -> grant order 0,1,0; one IDLE cycle between bursts.
- Isolation: while master0 is in W, drive s1_wvalid=1 and s1_awvalid=1 -> s1_wready=s1_awready=s1_bvalid=0 throughout; master1 is granted after master0's B handshake.
- Backpressure: m_awready low 5 cycles, then m_wready toggling every cycle -> no beat lost or duplicated; beat_cnt equals accepted handshakes; state stays until wlast handshake.
- Overrun (MAX_BEATS=4): 6 beats with wlast only on beat 6 -> err_overrun rises on the 4th handshake and stays 1; the burst completes normally; flag clears only on ARESET.
- Reset mid-burst: assert ARESET during beat 2 of W -> next cycle all outputs 0, state IDLE, last_grant=1. A fresh request from both masters after reset grants master0.
